// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX/MEM and MEM/WB.
// Issues one data-SRAM request at a time and extends load data.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        ex_mem_req,
    input  logic        ex_mem_we,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [1:0]  ex_size,
    input  logic        ex_sign,
    input  logic        ex_has_ex,
    input  logic        wb_allowin,
    input  logic        flush,
    output logic        mem_allowin,
    output logic        mem_ready_go,
    output logic [31:0] mem_rdata,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        go_mem;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign accept = ex_valid & mem_allowin & ~flush;
    assign go_mem = ex_mem_req & ~ex_has_ex;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = go_mem ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d = data_sram_addr_ok ? S_DRAIN : S_EMPTY;
                end else if (data_sram_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = data_sram_data_ok ? S_EMPTY : S_DRAIN;
                end else if (data_sram_data_ok) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // accept already implies wb_allowin and no flush
                if (accept) begin
                    state_d = go_mem ? S_REQ : S_DONE;
                end else if (flush || wb_allowin) begin
                    state_d = S_EMPTY;
                end
            end
            S_DRAIN: begin
                if (data_sram_data_ok) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        mem_allowin   = 1'b0;
        mem_ready_go  = 1'b0;
        data_sram_req = 1'b0;
        unique case (state_q)
            S_EMPTY: mem_allowin = 1'b1;
            S_REQ:   data_sram_req = 1'b1;
            S_DONE: begin
                mem_allowin  = wb_allowin;
                mem_ready_go = ~flush;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = data_sram_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = data_sram_rdata[{addr_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'd0:    load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
            default: load_ext = data_sram_rdata;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        if (accept) begin
            addr_d  = ex_addr;
            wdata_d = ex_wdata;
            size_d  = ex_size;
            sign_d  = ex_sign;
            we_d    = ex_mem_we;
            rdata_d = 32'h0;
        end
        // a response that races a flush is dropped with the instruction
        if (state_q == S_WAIT && data_sram_data_ok && !flush) begin
            rdata_d = we_q ? 32'h0 : load_ext;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        data_sram_wdata = wdata_q;
        unique case (size_q)
            2'd0: begin
                data_sram_wstrb = 4'b0001 << addr_q[1:0];
                data_sram_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{wdata_q[15:0]}};
            end
            default: data_sram_wstrb = 4'b1111;
        endcase
        if (!we_q) begin
            data_sram_wstrb = 4'b0000;
        end
    end

    assign data_sram_wr   = we_q;
    assign data_sram_size = size_q;
    assign data_sram_addr = addr_q;
    assign mem_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Each scenario task drives vectors and checks hand-computed values.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        ex_valid;
    logic        ex_mem_req;
    logic        ex_mem_we;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [1:0]  ex_size;
    logic        ex_sign;
    logic        ex_has_ex;
    logic        wb_allowin;
    logic        flush;
    logic        mem_allowin;
    logic        mem_ready_go;
    logic [31:0] mem_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int n_cmp;
    int n_err;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_valid          (ex_valid),
        .ex_mem_req        (ex_mem_req),
        .ex_mem_we         (ex_mem_we),
        .ex_addr           (ex_addr),
        .ex_wdata          (ex_wdata),
        .ex_size           (ex_size),
        .ex_sign           (ex_sign),
        .ex_has_ex         (ex_has_ex),
        .wb_allowin        (wb_allowin),
        .flush             (flush),
        .mem_allowin       (mem_allowin),
        .mem_ready_go      (mem_ready_go),
        .mem_rdata         (mem_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached before summary");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ex_valid          = 1'b0;
        ex_mem_req        = 1'b0;
        ex_mem_we         = 1'b0;
        ex_addr           = 32'h0;
        ex_wdata          = 32'h0;
        ex_size           = 2'd0;
        ex_sign           = 1'b0;
        ex_has_ex         = 1'b0;
        wb_allowin        = 1'b1;
        flush             = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
    endtask

    task automatic offer(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input logic sg);
        ex_valid   = 1'b1;
        ex_mem_req = 1'b1;
        ex_mem_we  = we;
        ex_addr    = a;
        ex_wdata   = wd;
        ex_size    = sz;
        ex_sign    = sg;
    endtask

    // Accept from EMPTY, immediate addr_ok, data_ok the next cycle;
    // returns mem_rdata seen in DONE and leaves the stage EMPTY.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz,
                            input logic sg, input logic [31:0] rd,
                            output logic [31:0] res);
        step();
        offer(1'b0, a, 32'h0, sz, sg);
        step();
        ex_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = rd;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        settle();
        res = mem_rdata;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req: got %b want 0", data_sram_req);
        end
        n_cmp++;
        if (mem_allowin !== 1'b1 || mem_ready_go !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: got allowin=%b ready=%b want 1/0",
                     mem_allowin, mem_ready_go);
        end
        n_cmp++;
        if (mem_rdata !== 32'h0 || data_sram_addr !== 32'h0
            || data_sram_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got rd=%h a=%h wd=%h want 0",
                     mem_rdata, data_sram_addr, data_sram_wdata);
        end
        n_cmp++;
        if (data_sram_wr !== 1'b0 || data_sram_size !== 2'd0
            || data_sram_wstrb !== 4'h0) begin
            n_err++;
            $display("FAIL reset_ctl: got wr=%b sz=%0d st=%b want 0",
                     data_sram_wr, data_sram_size, data_sram_wstrb);
        end
        step();
        resetn = 1'b1;
    endtask

    task automatic test_word_load();
        step();
        offer(1'b0, 32'h1000, 32'h0, 2'd2, 1'b0);
        settle();
        n_cmp++;
        if (mem_allowin !== 1'b1) begin
            n_err++;
            $display("FAIL wl_allowin: got %b want 1", mem_allowin);
        end
        step();
        ex_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1000
            || data_sram_wr !== 1'b0 || data_sram_wstrb !== 4'h0
            || data_sram_size !== 2'd2 || mem_allowin !== 1'b0) begin
            n_err++;
            $display("FAIL wl_req: got req=%b a=%h wr=%b st=%b sz=%0d al=%b want 1/1000/0/0000/2/0",
                     data_sram_req, data_sram_addr, data_sram_wr,
                     data_sram_wstrb, data_sram_size, mem_allowin);
        end
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h89ABCDEF;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b0 || mem_ready_go !== 1'b0) begin
            n_err++;
            $display("FAIL wl_wait: got req=%b ready=%b want 0/0",
                     data_sram_req, mem_ready_go);
        end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b1 || mem_rdata !== 32'h89ABCDEF) begin
            n_err++;
            $display("FAIL wl_done: got ready=%b rd=%h want 1/89abcdef",
                     mem_ready_go, mem_rdata);
        end
        step();
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b0 || mem_allowin !== 1'b1) begin
            n_err++;
            $display("FAIL wl_empty: got ready=%b al=%b want 0/1",
                     mem_ready_go, mem_allowin);
        end
    endtask

    task automatic test_ext_load();
        logic [31:0] r;
        run_load(32'h1003, 2'd0, 1'b1, 32'h80123456, r);
        n_cmp++;
        if (r !== 32'hFFFFFF80) begin
            n_err++;
            $display("FAIL ld_b: got %h want ffffff80", r);
        end
        run_load(32'h1003, 2'd0, 1'b0, 32'h80123456, r);
        n_cmp++;
        if (r !== 32'h00000080) begin
            n_err++;
            $display("FAIL ld_bu: got %h want 00000080", r);
        end
        run_load(32'h1002, 2'd1, 1'b1, 32'h80123456, r);
        n_cmp++;
        if (r !== 32'hFFFF8012) begin
            n_err++;
            $display("FAIL ld_h: got %h want ffff8012", r);
        end
        run_load(32'h1000, 2'd1, 1'b0, 32'h80123456, r);
        n_cmp++;
        if (r !== 32'h00003456) begin
            n_err++;
            $display("FAIL ld_hu: got %h want 00003456", r);
        end
        run_load(32'h1001, 2'd0, 1'b1, 32'h80123456, r);
        n_cmp++;
        if (r !== 32'h00000034) begin
            n_err++;
            $display("FAIL ld_b1: got %h want 00000034", r);
        end
    endtask

    task automatic test_store();
        step();
        offer(1'b1, 32'h2002, 32'h0000BEEF, 2'd1, 1'b0);
        step();
        ex_valid = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b1 || data_sram_wr !== 1'b1
            || data_sram_size !== 2'd1 || data_sram_wstrb !== 4'b1100
            || data_sram_wdata !== 32'hBEEFBEEF
            || data_sram_addr !== 32'h2002) begin
            n_err++;
            $display("FAIL st_h: got req=%b wr=%b sz=%0d st=%b wd=%h a=%h want 1/1/1/1100/beefbeef/2002",
                     data_sram_req, data_sram_wr, data_sram_size,
                     data_sram_wstrb, data_sram_wdata, data_sram_addr);
        end
        step();
        data_sram_addr_ok = 1'b1;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h2002) begin
            n_err++;
            $display("FAIL st_hold: got req=%b a=%h want 1/2002",
                     data_sram_req, data_sram_addr);
        end
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h55555555;
        step();
        data_sram_data_ok = 1'b0;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b1 || mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL st_done: got ready=%b rd=%h want 1/0",
                     mem_ready_go, mem_rdata);
        end
        step();
        offer(1'b1, 32'h2001, 32'h123456A5, 2'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_wstrb !== 4'b0010
            || data_sram_wdata !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL st_b: got st=%b wd=%h want 0010/a5a5a5a5",
                     data_sram_wstrb, data_sram_wdata);
        end
        // abandon it with a flush before addr_ok: back to EMPTY
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b0 || mem_allowin !== 1'b1) begin
            n_err++;
            $display("FAIL req_flush: got req=%b al=%b want 0/1",
                     data_sram_req, mem_allowin);
        end
    endtask

    task automatic test_no_mem();
        step();
        ex_valid = 1'b1;
        ex_mem_req = 1'b0;
        step();
        ex_valid = 1'b0;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b1 || data_sram_req !== 1'b0) begin
            n_err++;
            $display("FAIL nomem: got ready=%b req=%b want 1/0",
                     mem_ready_go, data_sram_req);
        end
        step();
        offer(1'b0, 32'h1001, 32'h0, 2'd2, 1'b0);
        ex_has_ex = 1'b1;
        step();
        ex_valid = 1'b0;
        ex_has_ex = 1'b0;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b1 || data_sram_req !== 1'b0) begin
            n_err++;
            $display("FAIL has_ex: got ready=%b req=%b want 1/0",
                     mem_ready_go, data_sram_req);
        end
        step();
        flush = 1'b1;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b0) begin
            n_err++;
            $display("FAIL done_flush: got ready=%b want 0", mem_ready_go);
        end
        step();
        flush = 1'b0;
        offer(1'b0, 32'h1000, 32'h0, 2'd2, 1'b0);
        flush = 1'b1;
        step();
        ex_valid = 1'b0;
        flush = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b0 || mem_allowin !== 1'b1
            || mem_ready_go !== 1'b0) begin
            n_err++;
            $display("FAIL flush_accept: got req=%b al=%b ready=%b want 0/1/0",
                     data_sram_req, mem_allowin, mem_ready_go);
        end
    endtask

    task automatic test_back_to_back();
        step();
        offer(1'b0, 32'h1004, 32'h0, 2'd2, 1'b0);
        step();
        ex_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h12345678;
        wb_allowin = 1'b0;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        offer(1'b0, 32'h1008, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++;
            if (mem_ready_go !== 1'b1 || mem_rdata !== 32'h12345678
                || mem_allowin !== 1'b0 || data_sram_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_%0d: got ready=%b rd=%h al=%b req=%b want 1/12345678/0/0",
                         i, mem_ready_go, mem_rdata, mem_allowin,
                         data_sram_req);
            end
            step();
        end
        wb_allowin = 1'b1;
        settle();
        n_cmp++;
        if (mem_allowin !== 1'b1 || mem_ready_go !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got al=%b ready=%b want 1/1",
                     mem_allowin, mem_ready_go);
        end
        step();
        ex_valid = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1008) begin
            n_err++;
            $display("FAIL b2b_req: got req=%b a=%h want 1/1008",
                     data_sram_req, data_sram_addr);
        end
        step();
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFEF00D;
        step();
        data_sram_data_ok = 1'b0;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL b2b_done: got ready=%b rd=%h want 1/cafef00d",
                     mem_ready_go, mem_rdata);
        end
        step();
    endtask

    task automatic test_flush_wait();
        logic [31:0] r;
        step();
        offer(1'b0, 32'h1100, 32'h0, 2'd2, 1'b0);
        step();
        ex_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        settle();
        n_cmp++;
        if (mem_ready_go !== 1'b0 || mem_allowin !== 1'b0) begin
            n_err++;
            $display("FAIL fw_wait: got ready=%b al=%b want 0/0",
                     mem_ready_go, mem_allowin);
        end
        step();
        flush = 1'b0;
        offer(1'b0, 32'h1200, 32'h0, 2'd2, 1'b0);
        settle();
        n_cmp++;
        if (mem_allowin !== 1'b0 || data_sram_req !== 1'b0
            || mem_ready_go !== 1'b0) begin
            n_err++;
            $display("FAIL fw_drain: got al=%b req=%b ready=%b want 0/0/0",
                     mem_allowin, data_sram_req, mem_ready_go);
        end
        step();
        ex_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBAD0BAD0;
        settle();
        n_cmp++;
        if (mem_allowin !== 1'b0 || mem_ready_go !== 1'b0
            || data_sram_req !== 1'b0) begin
            n_err++;
            $display("FAIL fw_drain2: got al=%b ready=%b req=%b want 0/0/0",
                     mem_allowin, mem_ready_go, data_sram_req);
        end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        settle();
        n_cmp++;
        if (mem_allowin !== 1'b1 || mem_ready_go !== 1'b0
            || mem_rdata === 32'hBAD0BAD0) begin
            n_err++;
            $display("FAIL fw_empty: got al=%b ready=%b rd=%h want 1/0/not bad0bad0",
                     mem_allowin, mem_ready_go, mem_rdata);
        end
        run_load(32'h1104, 2'd2, 1'b0, 32'h0F0F0F0F, r);
        n_cmp++;
        if (r !== 32'h0F0F0F0F) begin
            n_err++;
            $display("FAIL fw_next: got %h want 0f0f0f0f", r);
        end
    endtask

    task automatic test_reset_mid();
        step();
        offer(1'b0, 32'h3000, 32'h0, 2'd2, 1'b0);
        step();
        ex_valid = 1'b0;
        settle();
        n_cmp++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h3000) begin
            n_err++;
            $display("FAIL rm_req: got req=%b a=%h want 1/3000",
                     data_sram_req, data_sram_addr);
        end
        #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (data_sram_req !== 1'b0 || data_sram_addr !== 32'h0
            || mem_allowin !== 1'b1) begin
            n_err++;
            $display("FAIL rm_async: got req=%b a=%h al=%b want 0/0/1",
                     data_sram_req, data_sram_addr, mem_allowin);
        end
        step();
        resetn = 1'b1;
        settle();
        n_cmp++;
        if (mem_allowin !== 1'b1 || data_sram_req !== 1'b0
            || mem_ready_go !== 1'b0) begin
            n_err++;
            $display("FAIL rm_release: got al=%b req=%b ready=%b want 1/0/0",
                     mem_allowin, data_sram_req, mem_ready_go);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_word_load();
        test_ext_load();
        test_store();
        test_no_mem();
        test_back_to_back();
        test_flush_wait();
        test_reset_mid();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
